// File: rtl/lsu_dtcm_master.sv
// lsu_dtcm_master
//   LSU-side initiator on the lsu2dtcm cmd/rsp interface. It takes one load or
//   store from the AGU and checks the alignment and the DTCM address window.
//   It builds the byte mask and the lane-replicated write data, then issues a
//   single cmd beat. It waits for the response, extracts and extends the load
//   data, and hands the result to writeback. Only one transaction is in flight
//   at a time.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   agu_req_*            request from the AGU (valid/ready)
//   lsu2dtcm_cmd_*       single-beat command to dtcm_ctrl (valid/ready)
//   lsu2dtcm_rsp_*       response from dtcm_ctrl (valid/ready)
//   lsu_o_*              result to writeback (valid/ready)
//
// Handshake rule (all four channels): a transfer happens on a rising edge where
// valid and ready are both high. Once this block raises a valid, it holds that
// valid and its payload stable until the transfer happens. Reset is the only
// exception.
module lsu_dtcm_master #(
    parameter int          AW        = 16,
    parameter int          DW        = 32,
    parameter int          MW        = 4,
    parameter logic [31:0] DTCM_BASE = 32'h8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          agu_req_valid,
    output logic          agu_req_ready,
    input  logic          agu_req_load,
    input  logic [31:0]   agu_req_addr,
    input  logic [1:0]    agu_req_size,
    input  logic          agu_req_usign,
    input  logic [31:0]   agu_req_wdata,
    output logic          lsu2dtcm_cmd_valid,
    input  logic          lsu2dtcm_cmd_ready,
    output logic          lsu2dtcm_cmd_read,
    output logic [AW-1:0] lsu2dtcm_cmd_addr,
    output logic [MW-1:0] lsu2dtcm_cmd_wmask,
    output logic [DW-1:0] lsu2dtcm_cmd_wdata,
    input  logic          lsu2dtcm_rsp_valid,
    output logic          lsu2dtcm_rsp_ready,
    input  logic [DW-1:0] lsu2dtcm_rsp_rdata,
    output logic          lsu_o_valid,
    input  logic          lsu_o_ready,
    output logic [31:0]   lsu_o_rdata,
    output logic          lsu_o_store,
    output logic          lsu_o_misalgn,
    output logic          lsu_o_buserr
);

    typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;

    state_t      state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_usign;
    logic        r_load;
    logic [3:0]  r_mask;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_misalgn;
    logic        r_buserr;

    // Request decode, used only in the accept cycle.
    logic        req_misalgn;
    logic        req_outwin;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata;

    always_comb begin
        req_misalgn = 1'b0;
        req_mask    = 4'b1111;
        req_wdata   = agu_req_wdata;
        case (agu_req_size)
            2'b00: begin
                req_mask  = 4'b0001 << agu_req_addr[1:0];
                req_wdata = {4{agu_req_wdata[7:0]}};
            end
            2'b01: begin
                req_misalgn = agu_req_addr[0];
                req_mask    = 4'b0011 << {agu_req_addr[1], 1'b0};
                req_wdata   = {2{agu_req_wdata[15:0]}};
            end
            2'b10:   req_misalgn = (agu_req_addr[1:0] != 2'b00);
            default: req_misalgn = 1'b1;
        endcase
        req_outwin = (agu_req_addr[31:AW] != DTCM_BASE[31:AW]);
    end

    // Load data extraction. The response data is valid only in the handshake
    // cycle, so it is extended here and captured already in its final form.
    logic [31:0] rsp_lane;
    logic [31:0] rsp_ext;

    always_comb begin
        rsp_lane = 32'(lsu2dtcm_rsp_rdata) >> {r_addr[1:0], 3'b000};
        case (r_size)
            2'b00:   rsp_ext = r_usign ? {24'd0, rsp_lane[7:0]}
                                       : {{24{rsp_lane[7]}}, rsp_lane[7:0]};
            2'b01:   rsp_ext = r_usign ? {16'd0, rsp_lane[15:0]}
                                       : {{16{rsp_lane[15]}}, rsp_lane[15:0]};
            default: rsp_ext = rsp_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r_addr    <= '0;
            r_size    <= '0;
            r_usign   <= 1'b0;
            r_load    <= 1'b0;
            r_mask    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_misalgn <= 1'b0;
            r_buserr  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (agu_req_valid) begin
                    r_addr    <= agu_req_addr;
                    r_size    <= agu_req_size;
                    r_usign   <= agu_req_usign;
                    r_load    <= agu_req_load;
                    r_mask    <= req_mask;
                    r_wdata   <= req_wdata;
                    r_rdata   <= '0;
                    // A misaligned access is reported as misaligned, not as a bus error.
                    r_misalgn <= req_misalgn;
                    r_buserr  <= req_outwin & ~req_misalgn;
                    state     <= (req_misalgn | req_outwin) ? DONE : CMD;
                end
                CMD: if (lsu2dtcm_cmd_ready) state <= RSP;
                RSP: if (lsu2dtcm_rsp_valid) begin
                    r_rdata <= r_load ? rsp_ext : 32'd0;
                    state   <= DONE;
                end
                DONE: if (lsu_o_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is decoded from the registered state and payload. Payload
    // outputs are forced to zero whenever their valid is low.
    logic in_cmd;
    logic in_done;
    assign in_cmd  = (state == CMD);
    assign in_done = (state == DONE);

    assign agu_req_ready      = (state == IDLE);
    assign lsu2dtcm_cmd_valid = in_cmd;
    assign lsu2dtcm_cmd_read  = in_cmd & r_load;
    assign lsu2dtcm_cmd_addr  = in_cmd ? r_addr[AW-1:0] : '0;
    assign lsu2dtcm_cmd_wmask = (in_cmd & ~r_load) ? MW'(r_mask) : '0;
    assign lsu2dtcm_cmd_wdata = in_cmd ? DW'(r_wdata) : '0;
    assign lsu2dtcm_rsp_ready = (state == RSP);
    assign lsu_o_valid        = in_done;
    assign lsu_o_rdata        = in_done ? r_rdata : 32'd0;
    assign lsu_o_store        = in_done & ~r_load;
    assign lsu_o_misalgn      = in_done & r_misalgn;
    assign lsu_o_buserr       = in_done & r_buserr;

endmodule

// File: tb/tb_lsu_dtcm_master.sv
module tb_lsu_dtcm_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        agu_req_valid, agu_req_ready, agu_req_load, agu_req_usign;
    logic [31:0] agu_req_addr, agu_req_wdata;
    logic [1:0]  agu_req_size;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [15:0] cmd_addr;
    logic [3:0]  cmd_wmask;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        o_valid, o_ready, o_store, o_misalgn, o_buserr;
    logic [31:0] o_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    lsu_dtcm_master dut (
        .clk(clk), .rst(rst),
        .agu_req_valid(agu_req_valid), .agu_req_ready(agu_req_ready),
        .agu_req_load(agu_req_load), .agu_req_addr(agu_req_addr),
        .agu_req_size(agu_req_size), .agu_req_usign(agu_req_usign),
        .agu_req_wdata(agu_req_wdata),
        .lsu2dtcm_cmd_valid(cmd_valid), .lsu2dtcm_cmd_ready(cmd_ready),
        .lsu2dtcm_cmd_read(cmd_read), .lsu2dtcm_cmd_addr(cmd_addr),
        .lsu2dtcm_cmd_wmask(cmd_wmask), .lsu2dtcm_cmd_wdata(cmd_wdata),
        .lsu2dtcm_rsp_valid(rsp_valid), .lsu2dtcm_rsp_ready(rsp_ready),
        .lsu2dtcm_rsp_rdata(rsp_rdata),
        .lsu_o_valid(o_valid), .lsu_o_ready(o_ready), .lsu_o_rdata(o_rdata),
        .lsu_o_store(o_store), .lsu_o_misalgn(o_misalgn), .lsu_o_buserr(o_buserr)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural result of a load, from byte-lane arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input bit usign, input logic [31:0] rdata);
        logic [31:0] lane, v;
        lane = rdata >> (8 * (addr % 4));
        if (size == 2'd0) begin
            v = lane % 256;
            if (!usign && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = lane % 65536;
            if (!usign && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic bit model_misalgn(input logic [31:0] addr, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] model_wmask(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd0) return 32'd1 << (addr % 4);
        if (size == 2'd1) return 32'd3 << (addr % 4);
        return 32'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input logic [1:0] size);
        if (size == 2'd0) return (wdata % 256) * 32'h0101_0101;
        if (size == 2'd1) return (wdata % 65536) * 32'h0001_0001;
        return wdata;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_req_ready"}, 32'(agu_req_ready), 32'd1);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_rsp_ready"}, 32'(rsp_ready), 32'd0);
        check({tag, "_o_valid"},   32'(o_valid), 32'd0);
        check({tag, "_o_flags"},   32'({o_store, o_misalgn, o_buserr}), 32'd0);
        check({tag, "_o_rdata"},   o_rdata, 32'd0);
    endtask

    // Driver for one complete transaction. Accept happens at edge T, and every
    // check samples on the falling edge after an active edge.
    task automatic do_txn(input bit load, input logic [31:0] addr, input logic [1:0] size,
                          input bit usign, input logic [31:0] wdata, input logic [31:0] rdata,
                          input int cmd_stall, input int out_stall);
        bit mis, berr;
        logic [31:0] exp_rd;
        mis  = model_misalgn(addr, size);
        berr = !mis && (addr / 65536 != 32'h8000);
        exp_q.push_back((load && !mis && !berr) ? model_load(addr, size, usign, rdata) : 32'd0);
        @(negedge clk);
        check("req_ready_before", 32'(agu_req_ready), 32'd1);
        agu_req_valid = 1'b1; agu_req_load = load; agu_req_addr = addr;
        agu_req_size = size; agu_req_usign = usign; agu_req_wdata = wdata;
        @(negedge clk);
        agu_req_valid = 1'b0;
        agu_req_addr = $urandom; agu_req_wdata = $urandom;
        if (mis || berr) begin
            check("err_no_cmd", 32'(cmd_valid), 32'd0);
        end else begin
            for (int i = 0; i <= cmd_stall; i++) begin
                check("cmd_valid", 32'(cmd_valid), 32'd1);
                check("cmd_read",  32'(cmd_read), 32'(load));
                check("cmd_addr",  32'(cmd_addr), addr % 65536);
                check("cmd_wmask", 32'(cmd_wmask), load ? 32'd0 : model_wmask(addr, size));
                if (!load) check("cmd_wdata", cmd_wdata, model_wdata(wdata, size));
                check("cmd_req_ready", 32'(agu_req_ready), 32'd0);
                check("cmd_rsp_ready", 32'(rsp_ready), 32'd0);
                cmd_ready = (i == cmd_stall);
                @(negedge clk);
            end
            cmd_ready = 1'b0;
            check("rsp_cmd_valid", 32'(cmd_valid), 32'd0);
            check("rsp_ready", 32'(rsp_ready), 32'd1);
            rsp_valid = 1'b1; rsp_rdata = rdata;
            @(negedge clk);
            rsp_valid = 1'b0; rsp_rdata = $urandom;
        end
        exp_rd = exp_q.pop_front();
        for (int i = 0; i <= out_stall; i++) begin
            check("o_valid",   32'(o_valid), 32'd1);
            check("o_rdata",   o_rdata, exp_rd);
            check("o_store",   32'(o_store), 32'(!load));
            check("o_misalgn", 32'(o_misalgn), 32'(mis));
            check("o_buserr",  32'(o_buserr), 32'(berr));
            check("o_cmd_valid", 32'(cmd_valid), 32'd0);
            check("o_req_ready", 32'(agu_req_ready), 32'd0);
            o_ready = (i == out_stall);
            @(negedge clk);
        end
        o_ready = 1'b0;
        check("after_o_valid", 32'(o_valid), 32'd0);
        check("after_req_ready", 32'(agu_req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        rst = 1'b1; agu_req_valid = 1'b0; agu_req_load = 1'b0; agu_req_addr = '0;
        agu_req_size = '0; agu_req_usign = 1'b0; agu_req_wdata = '0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; o_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Directed cases
        do_txn(1, 32'h8000_0010, 2'd2, 0, 32'h0, 32'hDEAD_BEEF, 0, 0);
        do_txn(0, 32'h8000_0003, 2'd0, 0, 32'h0000_00A5, 32'h1234_5678, 0, 0);
        do_txn(1, 32'h8000_0002, 2'd1, 0, 32'h0, 32'h8001_1234, 0, 0);
        do_txn(1, 32'h8000_0002, 2'd1, 1, 32'h0, 32'h8001_1234, 0, 0);
        do_txn(1, 32'h8000_0006, 2'd2, 0, 32'h0, 32'h0, 0, 0);
        do_txn(1, 32'h1000_0000, 2'd2, 0, 32'h0, 32'h0, 0, 0);
        do_txn(0, 32'h8000_0000, 2'd3, 0, 32'h0, 32'h0, 0, 0);
        do_txn(0, 32'h8000_FFFE, 2'd1, 0, 32'hCAFE_BABE, 32'h0, 3, 2);

        // Reset while waiting for the response, then a stray response
        @(negedge clk);
        agu_req_valid = 1'b1; agu_req_load = 1'b1; agu_req_addr = 32'h8000_0020;
        agu_req_size = 2'd2; cmd_ready = 1'b1;
        @(negedge clk);
        agu_req_valid = 1'b0;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("pre_rst_rsp_ready", 32'(rsp_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_in_rsp");
        rsp_valid = 1'b1; rsp_rdata = 32'h5555_AAAA;
        @(negedge clk);
        rsp_valid = 1'b0;
        check_idle("stray_rsp");
        do_txn(1, 32'h8000_0021, 2'd0, 0, 32'h0, 32'h0000_8000, 0, 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            a  = ($urandom_range(0, 7) == 0) ? $urandom : (32'h8000_0000 | 32'($urandom_range(0, 65535)));
            sz = 2'($urandom_range(0, 3));
            do_txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
